// File: rtl/model_sink_pkg.sv
// model_sink_pkg: shared types and constants for the stream sink model.
//   sink_state_e : sink FSM states (IDLE, RUN, DONE)
//   LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   ERR_CNT_W    : width of the saturating data-error counter
package model_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sink_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          ERR_CNT_W = 16;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the backpressure noise source.
// Ports:
//   clk   in  1   clock
//   rst_n in  1   asynchronous active-low reset, loads seed
//   en    in  1   advance one step per cycle while high
//   seed  in  16  reset value (must be nonzero; tie to a constant)
//   q     out 16  current LFSR state
module lfsr16
    import model_sink_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (en) begin
            // Shift left; the new LSB is the XOR of the tapped bits.
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/model_sink.sv
// model_sink: valid/ready stream sink with pseudo-random bounded backpressure,
// incrementing-sequence data checker and handshake protocol monitor.
// Ports:
//   clk       in  1          clock
//   rst_n     in  1          asynchronous active-low reset
//   en        in  1          run enable
//   data_b    in  WIDTH      stream data
//   vld_b     in  1          stream valid
//   rdy_b     out 1          stream ready (registered)
//   rcv_cnt   out 32         accepted transfers (wraps)
//   err_cnt   out 16         data mismatches (saturating)
//   data_err  out 1          sticky, set on first data mismatch
//   proto_err out 1          sticky, set when a stalled sender drops valid or changes data
//   done      out 1          high in DONE
module model_sink
    import model_sink_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] START      = '0,
    parameter int unsigned      NUM_XFER   = 0,
    parameter int unsigned      STALL_BITS = 2,
    parameter int unsigned      MAX_STALL  = 4,
    parameter logic [15:0]      SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     data_b,
    input  logic                 vld_b,
    output logic                 rdy_b,
    output logic [31:0]          rcv_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 data_err,
    output logic                 proto_err,
    output logic                 done
);

    localparam int          SCW        = $clog2(MAX_STALL + 1);
    localparam logic [15:0] STALL_MASK = 16'((32'd1 << STALL_BITS) - 32'd1);

    sink_state_e      state, state_next;
    logic [15:0]      lfsr;
    logic             lfsr_en;
    logic [SCW-1:0]   stall_cnt;
    logic [WIDTH-1:0] exp_data;
    logic [WIDTH-1:0] held_data;
    logic             hold;
    logic             xfer;
    logic             last_xfer;
    logic             stall_req;
    logic             rdy_next;

    assign lfsr_en = (state == RUN);

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .seed  (SEED),
        .q     (lfsr)
    );

    assign xfer      = vld_b & rdy_b;
    assign last_xfer = (NUM_XFER != 0) && xfer && (rcv_cnt == 32'(NUM_XFER - 1));
    // Masking keeps every LFSR bit in the expression regardless of STALL_BITS.
    assign stall_req = ((lfsr & STALL_MASK) == 16'h0000);
    assign done      = (state == DONE);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = RUN;
            // The final transfer wins over a simultaneous en drop: it was accepted.
            RUN:     if (last_xfer) state_next = DONE;
                     else if (!en)  state_next = IDLE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
        // stall_cnt already counts the current zero cycle, so the cap yields at most MAX_STALL.
        rdy_next = (state_next == RUN) && (!stall_req || (stall_cnt == SCW'(MAX_STALL)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy_b     <= 1'b0;
            stall_cnt <= '0;
            rcv_cnt   <= '0;
            err_cnt   <= '0;
            data_err  <= 1'b0;
            proto_err <= 1'b0;
            exp_data  <= START;
            hold      <= 1'b0;
            held_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            rdy_b <= rdy_next;

            if (state_next == RUN && !rdy_next) begin
                stall_cnt <= stall_cnt + 1'b1;
            end else begin
                stall_cnt <= '0;
            end

            if (xfer) begin
                rcv_cnt  <= rcv_cnt + 32'd1;
                // Resynchronise on the received word so one corrupt word is one error.
                exp_data <= data_b + 1'b1;
                if (data_b != exp_data) begin
                    data_err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end

            // A sender that saw valid without ready must hold both valid and data.
            hold      <= vld_b & ~rdy_b;
            held_data <= data_b;
            if (hold && (!vld_b || (data_b != held_data))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_model_sink.sv
module tb_model_sink;

    localparam logic [31:0] START = 32'd0;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] data_b;
    logic        vld_b;
    logic        rdy_b;
    logic [31:0] rcv_cnt;
    logic [15:0] err_cnt;
    logic        data_err;
    logic        proto_err;
    logic        done;

    // Auxiliary sinks for the stall-bound checks, driven with valid low.
    logic        s_en;
    logic        a_rdy, b_rdy;
    logic [31:0] a_rcv_cnt, b_rcv_cnt;
    logic [15:0] a_err_cnt, b_err_cnt;
    logic        a_data_err, b_data_err;
    logic        a_proto_err, b_proto_err;
    logic        a_done, b_done;

    int tests_run;
    int tests_failed;

    model_sink #(
        .WIDTH(32), .START(START), .NUM_XFER(100),
        .STALL_BITS(2), .MAX_STALL(4), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_b(data_b), .vld_b(vld_b),
        .rdy_b(rdy_b), .rcv_cnt(rcv_cnt), .err_cnt(err_cnt),
        .data_err(data_err), .proto_err(proto_err), .done(done)
    );

    model_sink #(
        .WIDTH(32), .START(32'd0), .NUM_XFER(0),
        .STALL_BITS(16), .MAX_STALL(3), .SEED(16'h0001)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(s_en), .data_b(32'd0), .vld_b(1'b0),
        .rdy_b(a_rdy), .rcv_cnt(a_rcv_cnt), .err_cnt(a_err_cnt),
        .data_err(a_data_err), .proto_err(a_proto_err), .done(a_done)
    );

    model_sink #(
        .WIDTH(32), .START(32'd0), .NUM_XFER(0),
        .STALL_BITS(1), .MAX_STALL(3), .SEED(16'h0001)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(s_en), .data_b(32'd0), .vld_b(1'b0),
        .rdy_b(b_rdy), .rcv_cnt(b_rcv_cnt), .err_cnt(b_err_cnt),
        .data_err(b_data_err), .proto_err(b_proto_err), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Incrementing source sequence; from index skip_at onward every word is one higher.
    function automatic logic [31:0] word_at(input int i, input int skip_at);
        logic [31:0] w;
        w = START + 32'(i);
        if (skip_at >= 0 && i >= skip_at) w = w + 32'd1;
        return w;
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b0;
        s_en   = 1'b0;
        vld_b  = 1'b0;
        data_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge. Presents words with valid held high; rdy_b sampled at a
    // negedge is the value the following posedge sees.
    task automatic drive_stream(input int n, input int skip_at, input int budget,
                                output int sent, output int max_gap);
        int   cyc;
        int   gap;
        logic took;
        sent    = 0;
        cyc     = 0;
        gap     = 0;
        max_gap = 0;
        vld_b   = 1'b1;
        data_b  = word_at(0, skip_at);
        while (sent < n && cyc < budget) begin
            took = rdy_b;
            @(negedge clk);
            cyc++;
            if (took) begin
                gap = 0;
                sent++;
                if (sent < n) data_b = word_at(sent, skip_at);
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
        end
        vld_b = 1'b0;
    endtask

    task automatic test_reset();
        int highs;
        do_reset();
        tests_run++;
        if (rdy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy_b: got %0b expected 0", rdy_b); end
        tests_run++;
        if (rcv_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_rcv_cnt: got %0d expected 0", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        tests_run++;
        if (data_err !== 1'b0) begin tests_failed++; $display("FAIL reset_data_err: got %0b expected 0", data_err); end
        tests_run++;
        if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL reset_proto_err: got %0b expected 0", proto_err); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0b expected 0", done); end
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy_b !== 1'b0) highs++;
        end
        tests_run++;
        if (highs != 0) begin tests_failed++; $display("FAIL reset_idle_rdy_b: got %0d ready cycles expected 0", highs); end
    endtask

    task automatic test_stream();
        int sent, max_gap, highs;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL stream_done_early: got %0b expected 0", done); end
        drive_stream(100, -1, 1000, sent, max_gap);
        tests_run++;
        if (sent != 100) begin tests_failed++; $display("FAIL stream_sent: got %0d expected 100 (cycle budget)", sent); end
        tests_run++;
        if (rcv_cnt !== 32'd100) begin tests_failed++; $display("FAIL stream_rcv_cnt: got %0d expected 100", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL stream_err_cnt: got %0d expected 0", err_cnt); end
        tests_run++;
        if (data_err !== 1'b0) begin tests_failed++; $display("FAIL stream_data_err: got %0b expected 0", data_err); end
        tests_run++;
        if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL stream_proto_err: got %0b expected 0", proto_err); end
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL stream_done: got %0b expected 1", done); end
        tests_run++;
        if (max_gap > 4) begin tests_failed++; $display("FAIL stream_max_gap: got %0d expected <= 4", max_gap); end
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            if (rdy_b !== 1'b0) highs++;
            @(negedge clk);
        end
        tests_run++;
        if (highs != 0) begin tests_failed++; $display("FAIL stream_rdy_after_done: got %0d ready cycles expected 0", highs); end
        tests_run++;
        if (rcv_cnt !== 32'd100) begin tests_failed++; $display("FAIL stream_rcv_cnt_hold: got %0d expected 100", rcv_cnt); end
    endtask

    task automatic test_data_error();
        int sent, max_gap;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        // Words 0,1,2,3,5,6,...,20: only the 5 arriving when 4 is expected is wrong.
        drive_stream(20, 4, 500, sent, max_gap);
        tests_run++;
        if (rcv_cnt !== 32'd20) begin tests_failed++; $display("FAIL derr_rcv_cnt: got %0d expected 20", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL derr_err_cnt: got %0d expected 1", err_cnt); end
        tests_run++;
        if (data_err !== 1'b1) begin tests_failed++; $display("FAIL derr_data_err: got %0b expected 1", data_err); end
        tests_run++;
        if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL derr_proto_err: got %0b expected 0", proto_err); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL derr_done: got %0b expected 0", done); end
    endtask

    task automatic test_proto_drop();
        do_reset();
        vld_b  = 1'b1;
        data_b = 32'd42;
        @(negedge clk);
        tests_run++;
        if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL pdrop_before: got %0b expected 0", proto_err); end
        vld_b = 1'b0;
        @(negedge clk);
        tests_run++;
        if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL pdrop_proto_err: got %0b expected 1", proto_err); end
        tests_run++;
        if (rcv_cnt !== 32'd0) begin tests_failed++; $display("FAIL pdrop_rcv_cnt: got %0d expected 0", rcv_cnt); end
    endtask

    task automatic test_proto_change();
        do_reset();
        vld_b  = 1'b1;
        data_b = 32'd7;
        repeat (2) @(negedge clk);
        tests_run++;
        if (proto_err !== 1'b0) begin tests_failed++; $display("FAIL pchg_steady_hold: got %0b expected 0", proto_err); end
        data_b = 32'd8;
        @(negedge clk);
        tests_run++;
        if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL pchg_proto_err: got %0b expected 1", proto_err); end
        vld_b = 1'b0;
        @(negedge clk);
        tests_run++;
        if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL pchg_sticky: got %0b expected 1", proto_err); end
    endtask

    task automatic test_reset_mid();
        int sent, max_gap;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        drive_stream(37, 10, 500, sent, max_gap);
        tests_run++;
        if (rcv_cnt !== 32'd37) begin tests_failed++; $display("FAIL rmid_rcv_before: got %0d expected 37", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd1) begin tests_failed++; $display("FAIL rmid_err_before: got %0d expected 1", err_cnt); end
        // Assert reset between clock edges; outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rcv_cnt !== 32'd0) begin tests_failed++; $display("FAIL rmid_rcv_cnt: got %0d expected 0", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL rmid_err_cnt: got %0d expected 0", err_cnt); end
        tests_run++;
        if (data_err !== 1'b0) begin tests_failed++; $display("FAIL rmid_data_err: got %0b expected 0", data_err); end
        tests_run++;
        if (rdy_b !== 1'b0) begin tests_failed++; $display("FAIL rmid_rdy_b: got %0b expected 0", rdy_b); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_stream(5, -1, 200, sent, max_gap);
        tests_run++;
        if (rcv_cnt !== 32'd5) begin tests_failed++; $display("FAIL rmid_rcv_after: got %0d expected 5", rcv_cnt); end
        tests_run++;
        if (err_cnt !== 16'd0) begin tests_failed++; $display("FAIL rmid_restart_err: got %0d expected 0", err_cnt); end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall_bound();
        int a_run, b_run, a_max, b_max, b_zeros;
        do_reset();
        s_en = 1'b1;
        tests_run++;
        if (a_rdy !== 1'b0) begin tests_failed++; $display("FAIL stall_a_rdy_idle: got %0b expected 0", a_rdy); end
        @(negedge clk);
        tests_run++;
        if (a_rdy !== 1'b1) begin tests_failed++; $display("FAIL stall_a_rdy_rise: got %0b expected 1", a_rdy); end
        a_run = 0; b_run = 0; a_max = 0; b_max = 0; b_zeros = 0;
        for (int i = 0; i < 300; i++) begin
            if (a_rdy === 1'b1) a_run = 0;
            else begin a_run++; if (a_run > a_max) a_max = a_run; end
            if (b_rdy === 1'b1) b_run = 0;
            else begin b_run++; b_zeros++; if (b_run > b_max) b_max = b_run; end
            @(negedge clk);
        end
        tests_run++;
        if (a_max > 3) begin tests_failed++; $display("FAIL stall_a_max_run: got %0d expected <= 3", a_max); end
        // Seed 1 keeps LFSR bit 0 low for the first several RUN cycles, so the cap is reached.
        tests_run++;
        if (b_max != 3) begin tests_failed++; $display("FAIL stall_b_max_run: got %0d expected 3", b_max); end
        tests_run++;
        if (b_zeros == 0) begin tests_failed++; $display("FAIL stall_b_stalls: got %0d stall cycles expected > 0", b_zeros); end
        s_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_en_drop: got a=%0b b=%0b expected 0 0", a_rdy, b_rdy);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        s_en   = 1'b0;
        vld_b  = 1'b0;
        data_b = '0;
        test_reset();
        test_stream();
        test_data_error();
        test_proto_drop();
        test_proto_change();
        test_reset_mid();
        test_stall_bound();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
